// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM request channel between NUM_REQ clients.
// Requester 0 is the ROM loader. While download_active is high, only it can win.
// Grants use fixed priority (lowest index wins) by default.
// Define SDRAM_ARB_RR_EN to use round-robin arbitration instead.
// Downstream handshake: sdr_req is a level that is held until a one-cycle sdr_rdy.
module sdram_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 25,
  parameter int DW      = 16
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  download_active,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]  req_be,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DW-1:0]         rd_data,
  output logic [NUM_REQ-1:0]    rd_valid,
  output logic [AW-1:0]         sdr_addr,
  output logic [DW-1:0]         sdr_data,
  output logic [1:0]            sdr_be,
  output logic                  sdr_we,
  output logic                  sdr_req,
  input  logic                  sdr_rdy,
  input  logic [DW-1:0]         sdr_q,
  output logic                  busy,
  output logic [2:0]            grant_idx
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        sdr_addr_q, sdr_addr_d;
  logic [DW-1:0]        sdr_data_q, sdr_data_d;
  logic [1:0]           sdr_be_q, sdr_be_d;
  logic                 sdr_we_q, sdr_we_d;
  logic                 sdr_req_q, sdr_req_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   rd_valid_q, rd_valid_d;
  logic [DW-1:0]        rd_data_q, rd_data_d;
  logic [2:0]           grant_idx_q, grant_idx_d;

  logic [NUM_REQ-1:0]   elig;
  logic [7:0]           elig8;
  logic                 win_vld;
  logic [2:0]           win_idx;

`ifdef SDRAM_ARB_RR_EN
  // rr_ptr holds the index at which the next search starts (last grant + 1).
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  int                   cand;
`endif

  // Select the winning requester from the eligible set.
  always_comb begin
    elig = req;
    if (download_active) elig = {{(NUM_REQ-1){1'b0}}, req[0]};
    elig8   = 8'(elig);
    win_vld = 1'b0;
    win_idx = '0;
`ifdef SDRAM_ARB_RR_EN
    cand = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_vld && elig8[cand[2:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[2:0];
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && elig8[i]) begin
        win_vld = 1'b1;
        win_idx = 3'(i);
      end
    end
`endif
  end

  // Next-state logic for the FSM and the output registers.
  always_comb begin
    state_d     = state_q;
    sdr_addr_d  = sdr_addr_q;
    sdr_data_d  = sdr_data_q;
    sdr_be_d    = sdr_be_q;
    sdr_we_d    = sdr_we_q;
    sdr_req_d   = sdr_req_q;
    rd_data_d   = rd_data_q;
    grant_idx_d = grant_idx_q;
    ack_d       = '0;
    rd_valid_d  = '0;
`ifdef SDRAM_ARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == 3'(i)) begin
              sdr_addr_d = req_addr[i*AW +: AW];
              sdr_data_d = req_data[i*DW +: DW];
              sdr_be_d   = req_be[i*2 +: 2];
              sdr_we_d   = req_we[i];
            end
          end
          grant_idx_d = win_idx;
`ifdef SDRAM_ARB_RR_EN
          if (win_idx == 3'(NUM_REQ-1)) rr_ptr_d = '0;
          else                          rr_ptr_d = win_idx + 3'd1;
`endif
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        sdr_req_d = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // Command fields stay frozen here; only completion changes anything.
        if (sdr_rdy) begin
          sdr_req_d = 1'b0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_q == 3'(i)) begin
              ack_d[i] = 1'b1;
              if (!sdr_we_q) rd_valid_d[i] = 1'b1;
            end
          end
          if (!sdr_we_q) rd_data_d = sdr_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sdr_addr_q  <= '0;
      sdr_data_q  <= '0;
      sdr_be_q    <= '0;
      sdr_we_q    <= 1'b0;
      sdr_req_q   <= 1'b0;
      ack_q       <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      grant_idx_q <= '0;
`ifdef SDRAM_ARB_RR_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sdr_addr_q  <= sdr_addr_d;
      sdr_data_q  <= sdr_data_d;
      sdr_be_q    <= sdr_be_d;
      sdr_we_q    <= sdr_we_d;
      sdr_req_q   <= sdr_req_d;
      ack_q       <= ack_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      grant_idx_q <= grant_idx_d;
`ifdef SDRAM_ARB_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign sdr_addr  = sdr_addr_q;
  assign sdr_data  = sdr_data_q;
  assign sdr_be    = sdr_be_q;
  assign sdr_we    = sdr_we_q;
  assign sdr_req   = sdr_req_q;
  assign ack       = ack_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign grant_idx = grant_idx_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter.
// It checks table-driven transactions, hand-written corner sequences, and random
// traffic against a grant-policy model. The model follows SDRAM_ARB_RR_EN when
// that macro is defined.
module tb_sdram_port_arbiter;
  localparam int NUM_REQ = 3;
  localparam int AW = 25;
  localparam int DW = 16;

  logic                  sys_clk = 1'b0;
  logic                  reset_n;
  logic                  download_active;
  logic [NUM_REQ-1:0]    req, req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ*2-1:0]  req_be;
  logic [NUM_REQ-1:0]    ack, rd_valid;
  logic [DW-1:0]         rd_data;
  logic [AW-1:0]         sdr_addr;
  logic [DW-1:0]         sdr_data;
  logic [1:0]            sdr_be;
  logic                  sdr_we, sdr_req, sdr_rdy, busy;
  logic [DW-1:0]         sdr_q;
  logic [2:0]            grant_idx;

  logic [AW-1:0] ra   [NUM_REQ];
  logic [DW-1:0] rdat [NUM_REQ];
  logic [1:0]    rbe  [NUM_REQ];

  typedef struct {
    logic        dl;
    logic [2:0]  mask;
    logic        we;
    logic [24:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] q;
    int          delay;
    int          exp_g;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rr_next = 0;
  logic [15:0] last_rd = '0;

  sdram_port_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .download_active(download_active),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .req_be(req_be), .ack(ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be), .sdr_we(sdr_we),
    .sdr_req(sdr_req), .sdr_rdy(sdr_rdy), .sdr_q(sdr_q), .busy(busy),
    .grant_idx(grant_idx)
  );

  always #5 sys_clk = ~sys_clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    req_be   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*DW +: DW] = rdat[i];
      req_be[i*2 +: 2]     = rbe[i];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    #1;
    repeat (2) @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
    last_rd = '0;
    rr_next = 0;
  endtask

  // Grant policy: the eligible set, then the lowest index or a round-robin search from rr_next.
  function automatic int model_pick(input logic dl, input logic [2:0] mask);
    logic [2:0] el;
    int c;
    el = dl ? (mask & 3'b001) : mask;
    if (el == 3'b000) return -1;
`ifdef SDRAM_ARB_RR_EN
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (rr_next + k) % NUM_REQ;
      if (el[c]) return c;
    end
`else
    for (int k = 0; k < NUM_REQ; k++) if (el[k]) return k;
`endif
    return -1;
  endfunction

  // One full transaction: issue the request, respond after v.delay cycles, then check completion.
  task automatic do_txn(input vec_t v, input bit tog, input bit drop);
    int n;
    logic stable;
    logic [2:0] exp_ack;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == v.exp_g) begin
        ra[i] = v.addr; rdat[i] = v.data; rbe[i] = v.be; req_we[i] = v.we;
      end else begin
        ra[i] = AW'($urandom); rdat[i] = DW'($urandom);
        rbe[i] = 2'($urandom); req_we[i] = 1'($urandom);
      end
    end
    download_active = v.dl;
    req = v.mask;
    n = 0;
    for (int k = 1; k <= 8 && n == 0; k++) begin
      step;
      if (sdr_req === 1'b1) n = k;
    end
    chk("sdr_req_latency", n, 2);
    if (n == 0) begin
      req = '0;
      repeat (6) step;
      return;
    end
    chk("grant_idx", grant_idx, v.exp_g);
    chk("sdr_addr", sdr_addr, v.addr);
    chk("sdr_data", sdr_data, v.data);
    chk("sdr_be_we", {sdr_be, sdr_we}, {v.be, v.we});
    chk("busy_in_wait", busy, 1);
    if (tog) download_active = ~v.dl;
    if (drop) req = '0;
    stable = 1'b1;
    repeat (v.delay) begin
      step;
      if (sdr_req !== 1'b1 || sdr_addr !== v.addr || sdr_data !== v.data ||
          sdr_be !== v.be || sdr_we !== v.we || ack !== '0) stable = 1'b0;
    end
    chk("wait_hold", stable, 1);
    sdr_rdy = 1'b1;
    sdr_q = v.q;
    step;
    sdr_rdy = 1'b0;
    sdr_q = DW'($urandom);
    req = '0;
    exp_ack = 3'b001 << v.exp_g;
    if (!v.we) last_rd = v.q;
    chk("ack", ack, exp_ack);
    chk("rd_valid", rd_valid, v.we ? 3'b000 : exp_ack);
    chk("rd_data", rd_data, last_rd);
    chk("sdr_req_drop", sdr_req, 0);
    step;
    chk("ack_one_cycle", {rd_valid, ack}, 0);
    chk("idle_after_txn", busy, 0);
    chk("rd_data_hold", rd_data, last_rd);
  endtask

  initial begin
    vec_t tbl [6];
    vec_t v;
    logic flag;
    int n, rise, prev_rise, g, exp_g;
    logic dl;
    logic [2:0] mask;

    tbl[0] = '{dl:1'b0, mask:3'b010, we:1'b0, addr:25'h0001000, data:16'h0000, be:2'b11, q:16'h1234, delay:5, exp_g:1};
    tbl[1] = '{dl:1'b0, mask:3'b100, we:1'b1, addr:25'h01ABCDE, data:16'hBEEF, be:2'b10, q:16'h0000, delay:2, exp_g:2};
    tbl[2] = '{dl:1'b1, mask:3'b101, we:1'b0, addr:25'h00000FE, data:16'h0000, be:2'b11, q:16'h5A5A, delay:1, exp_g:0};
    tbl[3] = '{dl:1'b0, mask:3'b001, we:1'b1, addr:25'h1FFFFFF, data:16'hFFFF, be:2'b11, q:16'h0000, delay:0, exp_g:0};
    tbl[4] = '{dl:1'b0, mask:3'b100, we:1'b0, addr:25'h0000000, data:16'h0000, be:2'b00, q:16'hFFFF, delay:3, exp_g:2};
    tbl[5] = '{dl:1'b1, mask:3'b111, we:1'b0, addr:25'h0123456, data:16'h0000, be:2'b11, q:16'h0001, delay:0, exp_g:0};

    reset_n = 1'b1;
    download_active = 1'b0;
    req = '0;
    req_we = '0;
    sdr_rdy = 1'b0;
    sdr_q = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ra[i] = '0; rdat[i] = '0; rbe[i] = '0;
    end

    // Reset state.
    #3 reset_n = 1'b0;
    #1;
    chk("reset_ctrl", {ack, rd_valid, sdr_we, sdr_req, busy, grant_idx, sdr_be}, 0);
    chk("reset_data", {rd_data, sdr_addr, sdr_data}, 0);
    repeat (2) step;
    reset_n = 1'b1;

    // While download_active is high, the other requesters stall; then the loader write goes through.
    download_active = 1'b1;
    req = 3'b110;
    flag = 1'b0;
    repeat (20) begin
      step;
      if (busy || sdr_req || ack != '0) flag = 1'b1;
    end
    chk("dl_stall_no_grant", flag, 0);
    v = '{dl:1'b1, mask:3'b111, we:1'b1, addr:25'h0000100, data:16'hA5A5, be:2'b01, q:16'h0000, delay:0, exp_g:0};
    do_txn(v, 0, 0);

    // Table of single transactions.
    for (int t = 0; t < 6; t++) do_txn(tbl[t], 0, 0);

    // Requester 2 drops req while in WAIT; its ack still arrives.
    v = '{dl:1'b0, mask:3'b100, we:1'b0, addr:25'h0000ABC, data:16'h0000, be:2'b11, q:16'h7777, delay:2, exp_g:2};
    do_txn(v, 0, 1);

    // sdr_rdy while IDLE is ignored.
    req = '0;
    sdr_rdy = 1'b1;
    step;
    sdr_rdy = 1'b0;
    chk("rdy_idle_no_ack", {rd_valid, ack}, 0);
    chk("rdy_idle_busy", busy, 0);
    step;
    chk("rdy_idle_stays", {busy, sdr_req}, 0);

    // Asynchronous reset in the middle of WAIT.
    download_active = 1'b0;
    ra[0] = 25'h0000055;
    req_we = 3'b000;
    req = 3'b001;
    n = 0;
    for (int k = 1; k <= 8 && n == 0; k++) begin
      step;
      if (sdr_req === 1'b1) n = k;
    end
    chk("reset_wait_reached", n != 0, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {sdr_req, ack, busy}, 0);
    req = '0;
    repeat (2) @(posedge sys_clk);
    #1 reset_n = 1'b1;
    last_rd = '0;
    rr_next = 0;
    flag = 1'b0;
    repeat (4) begin
      step;
      if (ack != '0 || busy || sdr_req) flag = 1'b1;
    end
    chk("after_reset_quiet", flag, 0);

    // All requests held permanently: check the grant order and the gap between sdr_req rises.
    download_active = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ra[i] = AW'(32'h100 * (i + 1) + 32'h7);
      rdat[i] = DW'($urandom);
      rbe[i] = 2'b11;
    end
    req_we = 3'b111;
    req = 3'b111;
    prev_rise = 0;
    for (int gi = 0; gi < 6; gi++) begin
`ifdef SDRAM_ARB_RR_EN
      exp_g = gi % NUM_REQ;
`else
      exp_g = 0;
`endif
      n = 0;
      for (int k = 1; k <= 10 && n == 0; k++) begin
        step;
        if (sdr_req === 1'b1) n = k;
      end
      chk("hold_all_rise", n != 0, 1);
      rise = cyc;
      chk("hold_all_grant", grant_idx, exp_g);
      chk("hold_all_addr", sdr_addr, ra[exp_g]);
      if (gi > 0) chk("rise_gap_ge3", (rise - prev_rise) >= 3, 1);
      prev_rise = rise;
      sdr_rdy = 1'b1;
      step;
      sdr_rdy = 1'b0;
      chk("hold_all_ack", ack, 3'b001 << exp_g);
    end
    req = '0;
    repeat (3) step;

    // Random traffic checked against the policy model.
    do_reset;
    for (int it = 0; it < 40; it++) begin
      dl = 1'($urandom);
      mask = 3'($urandom_range(0, 7));
      g = model_pick(dl, mask);
      if (g < 0) begin
        download_active = dl;
        req = mask;
        flag = 1'b0;
        repeat (4) begin
          step;
          if (busy || sdr_req) flag = 1'b1;
        end
        chk("rand_no_grant", flag, 0);
        req = '0;
        step;
      end else begin
        v.dl = dl;
        v.mask = mask;
        v.we = 1'($urandom);
        v.addr = AW'($urandom);
        v.data = DW'($urandom);
        v.be = 2'($urandom);
        v.q = DW'($urandom);
        v.delay = $urandom_range(0, 4);
        v.exp_g = g;
        do_txn(v, 1'($urandom), 1'($urandom));
        rr_next = (g + 1) % NUM_REQ;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
